// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and control-field encodings shared by the RV32I controllers
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;
  localparam logic [1:0] ALU_ADD       = 2'b00;
  localparam logic [1:0] ALU_SUB       = 2'b01;
  localparam logic [1:0] ALU_FUNCT     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RD1      = 2'b10;
  localparam logic [1:0] SRCB_RD2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;
endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: opcode to immediate-format select, shared with the single-cycle core
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  always_comb
    imm_src = op == OP_STORE  ? IMM_S :
              op == OP_BRANCH ? IMM_B :
              op == OP_JAL    ? IMM_J : IMM_I;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);
  state_t r_state, w_next;
  logic w_br_ok, w_legal, w_pcw, w_irw, w_mw, w_rw, w_unused;
  assign w_unused = funct7_5;
  assign w_br_ok  = funct3 == 3'b000 || (SUPPORT_BNE && funct3 == 3'b001);
  assign w_legal  = op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL} || (op == OP_BRANCH && w_br_ok);
  always_ff @(posedge clk)
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:                w_next = DECODE;
      DECODE:               w_next = op inside {OP_LOAD, OP_STORE} ? MEMADR :
                                     op == OP_RTYPE ? EXEC_R :
                                     op == OP_ITYPE ? EXEC_I :
                                     op == OP_JAL   ? JAL    :
                                     w_legal        ? BRANCH : FETCH;
      MEMADR:               w_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:              w_next = MEMWB;
      EXEC_R, EXEC_I, JAL:  w_next = ALUWB;
      default:              w_next = FETCH;
    endcase
  end
  always_comb begin
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_mw       = 1'b0;
    w_rw       = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALU_ADD;
    case (r_state)
      FETCH: begin
        w_pcw      = 1'b1;
        w_irw      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        w_rw       = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        w_mw    = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ALUWB:    w_rw = 1'b1;
      JAL: begin
        w_pcw     = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      BRANCH: begin
        w_pcw     = zero ^ funct3[0];
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_SUB;
      end
      default: ;
    endcase
  end
  assign pc_write  = w_pcw & ~rst;
  assign ir_write  = w_irw & ~rst;
  assign mem_write = w_mw & ~rst;
  assign reg_write = w_rw & ~rst;
  assign illegal   = r_state == DECODE && !w_legal && !rst;
  assign state_dbg = STATE_W'(r_state);
  imm_src_decoder u_imm (.op(op), .imm_src(imm_src));
endmodule
